// File: rtl/csr_timer_intc.sv
// Stable counter, TID/TCFG/TVAL/TICLR timer CSRs and ESTAT.IS collection for the LoongArch32 core.
// CSR writes land on the write edge; external lines reach IS after two edges; int_req_o is combinational.
module csr_timer_intc #(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [7:0]  hw_int_i,
  input  logic        ipi_i,
  input  logic [12:0] ecfg_lie_i,
  input  logic        crmd_ie_i,
  output logic [31:0] tid_o,
  output logic [31:0] tcfg_o,
  output logic [31:0] tval_o,
  output logic [63:0] stable_cnt_o,
  output logic [12:0] estat_is_o,
  output logic        int_req_o
);

  localparam logic [13:0] ADDR_ESTAT = 14'h005;
  localparam logic [13:0] ADDR_TID   = 14'h040;
  localparam logic [13:0] ADDR_TCFG  = 14'h041;
  localparam logic [13:0] ADDR_TICLR = 14'h044;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_EXPIRED
  } tstate_t;

  tstate_t     state_q, state_d;
  logic [31:0] tid_q;
  logic [31:0] tcfg_q;
  logic [31:0] tval_q, tval_d;
  logic [63:0] cnt_q;
  logic [1:0]  swi_q;
  logic        ti_q;
  logic        ti_set;
  logic [7:0]  hw_meta_q, hw_sync_q;
  logic        ipi_meta_q, ipi_sync_q;

  logic        wr_estat, wr_tid, wr_tcfg, wr_ticlr;
  logic [31:0] reload_cur, reload_new;

  assign wr_estat = csr_we && (csr_waddr == ADDR_ESTAT);
  assign wr_tid   = csr_we && (csr_waddr == ADDR_TID);
  assign wr_tcfg  = csr_we && (csr_waddr == ADDR_TCFG);
  assign wr_ticlr = csr_we && (csr_waddr == ADDR_TICLR);

  assign reload_cur = {tcfg_q[31:2], 2'b00};
  assign reload_new = {csr_wdata[31:2], 2'b00};

  // Expiry still raises TI even if a TCFG write overrides the reload in the same cycle.
  always_comb begin
    state_d = state_q;
    tval_d  = tval_q;
    ti_set  = 1'b0;
    case (state_q)
      T_RUN: begin
        if (tval_q != 32'h0) begin
          tval_d = tval_q - 32'h1;
        end else begin
          ti_set = 1'b1;
          if (tcfg_q[1]) begin
            tval_d = reload_cur;
          end else begin
            tval_d  = 32'hFFFF_FFFF;
            state_d = T_EXPIRED;
          end
        end
      end
      T_EXPIRED: tval_d = 32'hFFFF_FFFF;
      default: ;
    endcase
    if (wr_tcfg) begin
      tval_d  = reload_new;
      state_d = csr_wdata[0] ? T_RUN : T_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T_IDLE;
      tval_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      tval_q  <= tval_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tid_q      <= TID_RESET;
      tcfg_q     <= 32'h0;
      cnt_q      <= 64'h0;
      swi_q      <= 2'b00;
      ti_q       <= 1'b0;
      hw_meta_q  <= 8'h0;
      hw_sync_q  <= 8'h0;
      ipi_meta_q <= 1'b0;
      ipi_sync_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_q + 64'h1;
      hw_meta_q  <= hw_int_i;
      hw_sync_q  <= hw_meta_q;
      ipi_meta_q <= ipi_i;
      ipi_sync_q <= ipi_meta_q;
      if (wr_tid)   tid_q  <= csr_wdata;
      if (wr_tcfg)  tcfg_q <= csr_wdata;
      if (wr_estat) swi_q  <= csr_wdata[1:0];
      // A set in the same cycle as a clear leaves TI asserted.
      ti_q <= ti_set | (ti_q & ~(wr_ticlr & csr_wdata[0]));
    end
  end

  assign tid_o        = tid_q;
  assign tcfg_o       = tcfg_q;
  assign tval_o       = tval_q;
  assign stable_cnt_o = cnt_q;
  assign estat_is_o   = {ipi_sync_q, ti_q, 1'b0, hw_sync_q, swi_q};
  assign int_req_o    = crmd_ie_i & (|(estat_is_o & ecfg_lie_i));

endmodule

// File: tb/tb_csr_timer_intc.sv
// Bench for csr_timer_intc: directed scenarios plus randomized traffic against a closed-form timer model.
module tb_csr_timer_intc;

  localparam logic [31:0] TID_RST = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [7:0]  hw_int_i;
  logic        ipi_i;
  logic [12:0] ecfg_lie_i;
  logic        crmd_ie_i;
  logic [31:0] tid_o, tcfg_o, tval_o;
  logic [63:0] stable_cnt_o;
  logic [12:0] estat_is_o;
  logic        int_req_o;

  always #5 clk = ~clk;

  csr_timer_intc #(.TID_RESET(TID_RST)) dut (
    .clk(clk), .rst(rst), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .hw_int_i(hw_int_i), .ipi_i(ipi_i), .ecfg_lie_i(ecfg_lie_i), .crmd_ie_i(crmd_ie_i),
    .tid_o(tid_o), .tcfg_o(tcfg_o), .tval_o(tval_o), .stable_cnt_o(stable_cnt_o),
    .estat_is_o(estat_is_o), .int_req_o(int_req_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: timer behaviour is derived from the edge of the last TCFG write.
  longint      edge_n = 0, m_wedge = 0, m_rst_edge = 0;
  logic [31:0] m_cfg = '0, m_tid = '0;
  logic [1:0]  m_swi = '0;
  logic        m_ti = 1'b0;
  logic [7:0]  hw_q[$];
  logic        ipi_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic longint m_reload();
    return longint'({m_cfg[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] m_tval();
    longint n4, k;
    n4 = m_reload();
    k  = edge_n - m_wedge;
    if (!m_cfg[0]) return 32'(n4);
    if (m_cfg[1]) return 32'(n4 - (k % (n4 + 1)));
    return (k <= n4) ? 32'(n4 - k) : 32'hFFFF_FFFF;
  endfunction

  // Expiry edges: one period (4*InitVal+1) after the write, repeating if periodic.
  function automatic logic m_timer_event();
    longint per, k;
    if (!m_cfg[0]) return 1'b0;
    per = m_reload() + 1;
    k   = edge_n - m_wedge;
    if (m_cfg[1]) return (k > 0) && (k % per == 0);
    return k == per;
  endfunction

  function automatic logic [12:0] m_is();
    return {ipi_q[1], m_ti, 1'b0, hw_q[1], m_swi};
  endfunction

  task automatic model_edge();
    logic ev, clr;
    edge_n++;
    if (rst) begin
      m_cfg = '0; m_wedge = edge_n; m_rst_edge = edge_n;
      m_tid = TID_RST; m_swi = '0; m_ti = 1'b0;
      hw_q  = '{8'h0, 8'h0};
      ipi_q = '{1'b0, 1'b0};
    end else begin
      ev  = m_timer_event();
      clr = csr_we && (csr_waddr == 14'h044) && csr_wdata[0];
      if (ev) m_ti = 1'b1;
      else if (clr) m_ti = 1'b0;
      if (csr_we) begin
        case (csr_waddr)
          14'h005: m_swi = csr_wdata[1:0];
          14'h040: m_tid = csr_wdata;
          14'h041: begin m_cfg = csr_wdata; m_wedge = edge_n; end
          default: ;
        endcase
      end
      hw_q.push_front(hw_int_i);
      void'(hw_q.pop_back());
      ipi_q.push_front(ipi_i);
      void'(ipi_q.pop_back());
    end
  endtask

  task automatic compare_all();
    check("tid", tid_o, m_tid);
    check("tcfg", tcfg_o, m_cfg);
    check("tval", tval_o, m_tval());
    check("stable_cnt", stable_cnt_o, 64'(edge_n - m_rst_edge));
    check("estat_is", estat_is_o, m_is());
    check("int_req", int_req_o, crmd_ie_i & (|(m_is() & ecfg_lie_i)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic csr_wr(input logic [13:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_waddr = a; csr_wdata = d;
    step();
    csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0;
  endtask

  initial begin
    rst = 1'b1; csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0;
    hw_int_i = '0; ipi_i = 1'b0; ecfg_lie_i = '0; crmd_ie_i = 1'b0;

    // Reset values and counter start
    repeat (3) step();
    check("rst_tid", tid_o, TID_RST);
    check("rst_tval", tval_o, 32'h0);
    check("rst_is", estat_is_o, 13'h0);
    rst = 1'b0;
    step();
    check("cnt_first", stable_cnt_o, 64'd1);
    step();
    check("cnt_second", stable_cnt_o, 64'd2);

    // One-shot timer, InitVal=1
    ecfg_lie_i = 13'h800; crmd_ie_i = 1'b1;
    csr_wr(14'h041, 32'h0000_0005);
    check("oneshot_load", tval_o, 32'd4);
    for (int i = 3; i >= 0; i--) begin
      step();
      check("oneshot_tval", tval_o, 32'(i));
      check("oneshot_no_ti", estat_is_o[11], 1'b0);
    end
    step();
    check("oneshot_expired", tval_o, 32'hFFFF_FFFF);
    check("oneshot_ti", estat_is_o[11], 1'b1);
    check("oneshot_irq", int_req_o, 1'b1);
    repeat (3) step();
    check("oneshot_hold", tval_o, 32'hFFFF_FFFF);

    // Periodic timer, clear, then clear colliding with a set
    csr_wr(14'h044, 32'h1);
    check("ticlr", estat_is_o[11], 1'b0);
    csr_wr(14'h041, 32'h0000_0007);
    repeat (4) step();
    check("per_zero", tval_o, 32'd0);
    step();
    check("per_ti", estat_is_o[11], 1'b1);
    check("per_reload", tval_o, 32'd4);
    csr_wr(14'h044, 32'h1);
    check("per_clear", estat_is_o[11], 1'b0);
    repeat (3) step();
    check("per_zero2", tval_o, 32'd0);
    csr_wr(14'h044, 32'h1);
    check("set_beats_clear", estat_is_o[11], 1'b1);

    // Hardware interrupt line through the synchronizer
    csr_wr(14'h041, 32'h0);
    ecfg_lie_i = 13'h020; crmd_ie_i = 1'b0;
    hw_int_i = 8'h08;
    step();
    check("hw_rise_1", estat_is_o[5], 1'b0);
    step();
    check("hw_rise_2", estat_is_o[5], 1'b1);
    check("hw_ie0", int_req_o, 1'b0);
    repeat (2) step();
    crmd_ie_i = 1'b1;
    #1;
    check("hw_ie1", int_req_o, 1'b1);
    hw_int_i = 8'h00;
    step();
    check("hw_fall_1", estat_is_o[5], 1'b1);
    step();
    check("hw_fall_2", estat_is_o[5], 1'b0);
    check("hw_irq_off", int_req_o, 1'b0);

    // Software interrupt, TID, read-only TVAL
    csr_wr(14'h005, 32'h3);
    check("swi", estat_is_o[1:0], 2'b11);
    csr_wr(14'h040, 32'hDEAD_BEEF);
    check("tid_wr", tid_o, 32'hDEAD_BEEF);
    csr_wr(14'h042, 32'h0000_FFFF);
    check("tval_ro", tval_o, 32'h0);

    // Reset in the middle of a count
    csr_wr(14'h041, 32'h0000_0011);
    repeat (13) step();
    check("mid_tval3", tval_o, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_tval", tval_o, 32'h0);
    check("mid_rst_tcfg", tcfg_o, 32'h0);
    check("mid_rst_is", estat_is_o, 13'h0);
    repeat (6) step();
    check("mid_rst_idle", tval_o, 32'h0);
    check("mid_rst_no_ti", estat_is_o[11], 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [13:0] a;
      logic [31:0] d;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) hw_int_i = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ipi_i = ~ipi_i;
      if ($urandom_range(0, 9) == 0) ecfg_lie_i = 13'($urandom);
      if ($urandom_range(0, 9) == 0) crmd_ie_i = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: a = 14'h005;
          1: a = 14'h040;
          2: a = 14'h041;
          3: a = 14'h042;
          4: a = 14'h044;
          default: a = 14'($urandom);
        endcase
        d = $urandom;
        if (a == 14'h041 && $urandom_range(0, 7) != 0)
          d = {30'($urandom_range(0, 6)), 2'($urandom)};
        csr_wr(a, d);
      end else begin
        step();
      end
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
